// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the RV32I datapath.
// Memory handshake: the sequencer holds mem_req high, and keeps AdrSrc and
// MemWrite stable, until mem_ready is seen high in the same cycle. That cycle
// completes the transfer. A cycle with mem_req=1 and mem_ready=0 is a stall.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       illegal;
  logic       retire;
  logic [3:0] state;

  // Sequencer side.
  modport master (
    input  op, funct3, funct7_5, zero, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
           illegal, retire, state
  );

  // Datapath side.
  modport slave (
    output op, funct3, funct7_5, zero, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
           illegal, retire, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-style multicycle sequencer for RV32I: fetch, decode, execute,
// memory and writeback over a shared ALU, register file and memory.
module multicycle_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  state_t state_q, state_d;

  logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c;
  logic       reg_write_c, illegal_c, retire_c;
  logic [1:0] result_src_c, src_a_c, src_b_c;
  logic [3:0] alu_ctl_c;
  logic [2:0] imm_src_c;

  // funct3 -> ALU operation; funct7_5 selects sub only for R-type, sra for both.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f75,
                                         input logic is_r);
    case (f3)
      3'b000:  alu_dec = (is_r && f75) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = f75 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction

  // State register; reset returns to FETCH asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    imm_src_c = 3'b000;
    case (bus.op)
      OP_SW:   imm_src_c = 3'b001;
      OP_BR:   imm_src_c = 3'b010;
      OP_JAL:  imm_src_c = 3'b011;
      OP_LUI:  imm_src_c = 3'b100;
      default: imm_src_c = 3'b000;
    endcase
  end

  // Next-state and datapath controls for the current state.
  always_comb begin
    state_d      = S_FETCH;
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    illegal_c    = 1'b0;
    retire_c     = 1'b0;
    result_src_c = 2'b00;
    src_a_c      = 2'b00;
    src_b_c      = 2'b00;
    alu_ctl_c    = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        src_b_c      = 2'b10;
        result_src_c = 2'b10;
        ir_write_c   = bus.mem_ready;
        pc_write_c   = bus.mem_ready;
        state_d      = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        src_a_c = 2'b01;
        src_b_c = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          OP_BR: begin
            if (bus.funct3 == 3'b000 || bus.funct3 == 3'b001) state_d = S_BRANCH;
            else illegal_c = 1'b1;
          end
          default:      illegal_c = 1'b1;
        endcase
      end
      S_MEMADR: begin
        src_a_c = 2'b10;
        src_b_c = 2'b01;
        state_d = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        state_d   = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
        retire_c     = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        retire_c    = bus.mem_ready;
        state_d     = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        src_a_c   = 2'b10;
        alu_ctl_c = alu_dec(bus.funct3, bus.funct7_5, 1'b1);
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        src_a_c   = 2'b10;
        src_b_c   = 2'b01;
        alu_ctl_c = alu_dec(bus.funct3, bus.funct7_5, 1'b0);
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
      end
      S_BRANCH: begin
        src_a_c    = 2'b10;
        alu_ctl_c  = ALU_SUB;
        pc_write_c = (bus.funct3 == 3'b000) ? bus.zero : ~bus.zero;
        retire_c   = 1'b1;
      end
      S_JAL: begin
        src_a_c    = 2'b01;
        src_b_c    = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_LUI: begin
        src_a_c = 2'b11;
        src_b_c = 2'b01;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables and pulses are held off for as long as reset is asserted.
  assign bus.mem_req    = mem_req_c   & rst_n;
  assign bus.MemWrite   = mem_write_c & rst_n;
  assign bus.IRWrite    = ir_write_c  & rst_n;
  assign bus.PCWrite    = pc_write_c  & rst_n;
  assign bus.RegWrite   = reg_write_c & rst_n;
  assign bus.illegal    = illegal_c   & rst_n;
  assign bus.retire     = retire_c    & rst_n;
  assign bus.AdrSrc     = adr_src_c;
  assign bus.ResultSrc  = result_src_c;
  assign bus.ALUSrcA    = src_a_c;
  assign bus.ALUSrcB    = src_b_c;
  assign bus.ALUControl = alu_ctl_c;
  assign bus.ImmSrc     = imm_src_c;
  assign bus.state      = state_q;
endmodule
